jc_spi_responder: RTL and testbench

JC_SPI_RESPONDER -- requirements
Module: jc_spi_responder

---
 rtl/jc_spi_responder.sv | 212 +++++++++++++++++++++
 tb/tb_jc_spi_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jc_spi_responder.sv
// SPI register-access responder for the AD9524-style protocol: 16-bit instruction
// (R/W, byte count W1:W0, 13-bit start address) followed by descending-address data bytes.
module jc_spi_responder #(
   parameter int SYNC_STAGES  = 2,
   parameter int SCLK_MIN_DIV = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        spi_sclk,
   input  logic        spi_cs,
   input  logic        spi_sdi,
   output logic        spi_sdo,
   output logic        spi_sdo_oe,
   output logic        reg_wr,
   output logic        reg_rd,
   output logic [12:0] reg_addr,
   output logic [7:0]  reg_wdata,
   input  logic [7:0]  reg_rdata,
   output logic        frame_active,
   output logic        frame_err
);

   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("jc_spi_responder: SYNC_STAGES must be 2 or 3");
   end
   if (SCLK_MIN_DIV < 3) begin : g_bad_div
      $error("jc_spi_responder: SCLK_MIN_DIV too small for the read prefetch path");
   end

   typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

   localparam logic [1:0] SETTLE_MAX = 2'(SYNC_STAGES);

   state_t state, next_state;

   logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
   logic        sclk_s, cs_s, sdi_s;
   logic        sclk_prev, cs_prev;
   logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [1:0]  settle_cnt;
   logic        armed;

   logic [14:0] instr_sr;
   logic [3:0]  bit_cnt;
   logic [6:0]  in_shift;
   logic [2:0]  data_cnt, data_cnt_inc;
   logic [2:0]  fall_cnt;
   logic [1:0]  byte_idx;
   logic [1:0]  w_field;
   logic        is_read;
   logic [7:0]  out_shift;
   logic [7:0]  rd_buf;
   logic        rd_load;
   logic        stream, last_byte;
   logic        instr_done, byte_done, start_frame;

   // Synchronizers reset to the idle bus levels. "armed" is only set once cs has been
   // seen high with the chains refilled, so a frame already in progress at reset release
   // is ignored until cs cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync  <= '0;
         cs_sync    <= '1;
         sdi_sync   <= '0;
         sclk_prev  <= 1'b0;
         cs_prev    <= 1'b1;
         settle_cnt <= '0;
         armed      <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
         sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
         sclk_prev <= sclk_s;
         cs_prev   <= cs_s;
         if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 2'd1;
         if (settle_cnt == SETTLE_MAX && cs_s) armed <= 1'b1;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev;
   assign sclk_fall = ~sclk_s & sclk_prev;
   assign cs_rise   = cs_s & ~cs_prev;
   assign cs_fall   = ~cs_s & cs_prev;

   assign stream       = (w_field == 2'b11);
   assign last_byte    = !stream && (byte_idx == w_field);
   assign instr_done   = (state == INSTR) && sclk_rise && (bit_cnt == 4'd15);
   assign byte_done    = (state == DATA) && sclk_rise && (data_cnt == 3'd7);
   assign start_frame  = (state == IDLE) && cs_fall && armed;
   assign data_cnt_inc = data_cnt + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:  if (start_frame) next_state = INSTR;
         INSTR: begin
            if (cs_rise)         next_state = IDLE;
            else if (instr_done) next_state = DATA;
         end
         DATA: begin
            if (cs_rise)                     next_state = IDLE;
            else if (byte_done && last_byte) next_state = DONE;
         end
         DONE:  if (cs_rise) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      frame_active = (state != IDLE);
      spi_sdo_oe   = (state == DATA) && is_read;
      spi_sdo      = spi_sdo_oe & out_shift[7];
   end

   // Read data passes through rd_buf, the load stage of the output shifter, because a
   // prefetch returns while bit 0 of the current byte is still on sdo; it moves into
   // out_shift on the first SCLK fall of the next byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         instr_sr  <= '0;
         bit_cnt   <= '0;
         in_shift  <= '0;
         data_cnt  <= '0;
         fall_cnt  <= '0;
         byte_idx  <= '0;
         w_field   <= '0;
         is_read   <= 1'b0;
         out_shift <= '0;
         rd_buf    <= '0;
         rd_load   <= 1'b0;
      end else begin
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         frame_err <= 1'b0;
         rd_load   <= reg_rd;
         if (rd_load) rd_buf <= reg_rdata;
         if (reg_wr)  reg_addr <= reg_addr - 13'd1;

         case (state)
            IDLE: begin
               if (start_frame) begin
                  bit_cnt  <= '0;
                  data_cnt <= '0;
                  fall_cnt <= '0;
                  byte_idx <= '0;
               end
            end

            INSTR: begin
               if (cs_rise) begin
                  frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  instr_sr <= {instr_sr[13:0], sdi_s};
                  bit_cnt  <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd15) begin
                     is_read  <= instr_sr[14];
                     w_field  <= instr_sr[13:12];
                     reg_addr <= {instr_sr[11:0], sdi_s};
                     reg_rd   <= instr_sr[14];
                     data_cnt <= '0;
                     fall_cnt <= '0;
                     byte_idx <= '0;
                  end
               end
            end

            // A write byte landing on the same clk as cs rising still completes.
            DATA: begin
               if (sclk_rise) begin
                  in_shift <= {in_shift[5:0], sdi_s};
                  data_cnt <= data_cnt_inc;
                  if (data_cnt == 3'd7) begin
                     byte_idx <= byte_idx + 2'd1;
                     if (!is_read) begin
                        reg_wr    <= 1'b1;
                        reg_wdata <= {in_shift, sdi_s};
                     end
                  end
               end
               if (cs_rise) begin
                  frame_err <= sclk_rise ? (data_cnt_inc != 3'd0) : (data_cnt != 3'd0);
               end else if (sclk_fall && is_read) begin
                  fall_cnt <= fall_cnt + 3'd1;
                  if (fall_cnt == 3'd0) out_shift <= rd_buf;
                  else                  out_shift <= {out_shift[6:0], 1'b0};
                  if (fall_cnt == 3'd7) begin
                     reg_addr <= reg_addr - 13'd1;
                     if (!last_byte) reg_rd <= 1'b1;
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jc_spi_responder.sv
// Directed bench for jc_spi_responder: an SPI master running at the minimum SCLK
// divider against a 3-stage synchronizer, plus a register-file model returning addr[7:0].
module tb_jc_spi_responder;

   localparam int HALF = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_sclk, spi_cs, spi_sdi;
   logic        spi_sdo, spi_sdo_oe;
   logic        reg_wr, reg_rd;
   logic [12:0] reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata = 8'h00;
   logic        frame_active, frame_err;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [12:0] wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   logic [12:0] rd_addr_q[$];
   int          err_pulses = 0;
   int          overlap    = 0;

   always #5 clk = ~clk;

   jc_spi_responder #(.SYNC_STAGES(3), .SCLK_MIN_DIV(HALF)) dut (
      .clk          (clk),
      .reset        (reset),
      .spi_sclk     (spi_sclk),
      .spi_cs       (spi_cs),
      .spi_sdi      (spi_sdi),
      .spi_sdo      (spi_sdo),
      .spi_sdo_oe   (spi_sdo_oe),
      .reg_wr       (reg_wr),
      .reg_rd       (reg_rd),
      .reg_addr     (reg_addr),
      .reg_wdata    (reg_wdata),
      .reg_rdata    (reg_rdata),
      .frame_active (frame_active),
      .frame_err    (frame_err)
   );

   // Register-file model: data for a read strobe is valid on the following clk.
   always @(posedge clk) begin
      if (reg_rd) reg_rdata <= reg_addr[7:0];
   end

   always @(negedge clk) begin
      if (reg_wr) begin
         wr_addr_q.push_back(reg_addr);
         wr_data_q.push_back(reg_wdata);
      end
      if (reg_rd) rd_addr_q.push_back(reg_addr);
      if (frame_err) err_pulses++;
      if (reg_wr && reg_rd) overlap++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] wrAddrAt(input int idx);
      return (idx < wr_addr_q.size()) ? 32'(wr_addr_q[idx]) : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] wrDataAt(input int idx);
      return (idx < wr_data_q.size()) ? 32'(wr_data_q[idx]) : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] rdAddrAt(input int idx);
      return (idx < rd_addr_q.size()) ? 32'(rd_addr_q[idx]) : 32'hDEAD_BEEF;
   endfunction

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clearLog();
      wr_addr_q.delete();
      wr_data_q.delete();
      rd_addr_q.delete();
      err_pulses = 0;
   endtask

   task automatic spiBegin();
      spi_cs = 1'b0;
      waitClk(HALF);
   endtask

   task automatic spiEnd();
      waitClk(HALF);
      spi_cs  = 1'b1;
      spi_sdi = 1'b0;
      waitClk(12);
   endtask

   // Shifts nbits of tx MSB-first; sdo is sampled just before each SCLK rise.
   task automatic applyStimulus(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_sdi = tx[7-i];
         waitClk(HALF);
         rx[7-i] = spi_sdo;
         spi_sclk = 1'b1;
         waitClk(HALF);
         spi_sclk = 1'b0;
      end
   endtask

   task automatic sendInstr(input logic [15:0] instr);
      logic [7:0] dummy;
      applyStimulus(instr[15:8], 8, dummy);
      applyStimulus(instr[7:0], 8, dummy);
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] wbytes [4];
      wbytes[0] = 8'h11;
      wbytes[1] = 8'h22;
      wbytes[2] = 8'h33;
      wbytes[3] = 8'h44;

      reset    = 1'b1;
      spi_sclk = 1'b0;
      spi_cs   = 1'b1;
      spi_sdi  = 1'b0;
      waitClk(3);
      checkOutput("rst reg_wr",       reg_wr,       0);
      checkOutput("rst reg_rd",       reg_rd,       0);
      checkOutput("rst reg_addr",     reg_addr,     0);
      checkOutput("rst reg_wdata",    reg_wdata,    0);
      checkOutput("rst frame_active", frame_active, 0);
      checkOutput("rst frame_err",    frame_err,    0);
      checkOutput("rst sdo",          spi_sdo,      0);
      checkOutput("rst sdo_oe",       spi_sdo_oe,   0);
      reset = 1'b0;
      waitClk(10);

      // 1-byte write
      clearLog();
      spiBegin();
      sendInstr(16'h0018);
      checkOutput("w1 frame_active", frame_active, 1);
      applyStimulus(8'hA5, 8, rx);
      spiEnd();
      checkOutput("w1 count",  wr_addr_q.size(), 1);
      checkOutput("w1 addr",   wrAddrAt(0), 32'h018);
      checkOutput("w1 data",   wrDataAt(0), 32'hA5);
      checkOutput("w1 err",    err_pulses, 0);
      checkOutput("w1 idle",   frame_active, 0);

      // 3-byte write with a 4th byte that must be ignored in DONE
      clearLog();
      spiBegin();
      sendInstr(16'h4232);
      checkOutput("w3 sdo_oe", spi_sdo_oe, 0);
      for (int b = 0; b < 4; b++) applyStimulus(wbytes[b], 8, rx);
      checkOutput("w3 done active", frame_active, 1);
      spiEnd();
      checkOutput("w3 count", wr_addr_q.size(), 3);
      checkOutput("w3 addr0", wrAddrAt(0), 32'h232);
      checkOutput("w3 addr1", wrAddrAt(1), 32'h231);
      checkOutput("w3 addr2", wrAddrAt(2), 32'h230);
      checkOutput("w3 data0", wrDataAt(0), 32'h11);
      checkOutput("w3 data1", wrDataAt(1), 32'h22);
      checkOutput("w3 data2", wrDataAt(2), 32'h33);
      checkOutput("w3 err",   err_pulses, 0);

      // streaming read across the address wrap
      clearLog();
      spiBegin();
      sendInstr(16'hE001);
      applyStimulus(8'h00, 8, rx);
      checkOutput("rs byte0", rx, 32'h01);
      checkOutput("rs sdo_oe", spi_sdo_oe, 1);
      applyStimulus(8'h00, 8, rx);
      checkOutput("rs byte1", rx, 32'h00);
      applyStimulus(8'h00, 8, rx);
      checkOutput("rs byte2", rx, 32'hFF);
      spiEnd();
      checkOutput("rs rd0", rdAddrAt(0), 32'h0001);
      checkOutput("rs rd1", rdAddrAt(1), 32'h0000);
      checkOutput("rs rd2", rdAddrAt(2), 32'h1FFF);
      checkOutput("rs rd>=3", rd_addr_q.size() >= 3, 1);
      checkOutput("rs no wr", wr_addr_q.size(), 0);
      checkOutput("rs err",   err_pulses, 0);
      checkOutput("rs oe off", spi_sdo_oe, 0);

      // 2-byte read: final prefetch suppressed, extra byte reads as 0 in DONE
      clearLog();
      spiBegin();
      sendInstr(16'hA050);
      applyStimulus(8'h00, 8, rx);
      checkOutput("r2 byte0", rx, 32'h50);
      applyStimulus(8'h00, 8, rx);
      checkOutput("r2 byte1", rx, 32'h4F);
      checkOutput("r2 done oe", spi_sdo_oe, 0);
      applyStimulus(8'h00, 8, rx);
      checkOutput("r2 byte2", rx, 32'h00);
      spiEnd();
      checkOutput("r2 rd count", rd_addr_q.size(), 2);
      checkOutput("r2 rd0", rdAddrAt(0), 32'h050);
      checkOutput("r2 rd1", rdAddrAt(1), 32'h04F);

      // abort after 5 data bits
      clearLog();
      spiBegin();
      sendInstr(16'h0010);
      applyStimulus(8'hFF, 5, rx);
      spiEnd();
      checkOutput("ab no wr", wr_addr_q.size(), 0);
      checkOutput("ab err",   err_pulses, 1);
      checkOutput("ab idle",  frame_active, 0);

      // abort inside the instruction phase
      clearLog();
      spiBegin();
      applyStimulus(8'h00, 8, rx);
      spiEnd();
      checkOutput("ai err", err_pulses, 1);
      checkOutput("ai no rd", rd_addr_q.size(), 0);

      // cs rises together with the 8th SCLK rise of a streaming write
      clearLog();
      spiBegin();
      sendInstr(16'h6100);
      applyStimulus(8'h3C, 7, rx);
      spi_sdi = 1'b0;
      waitClk(HALF);
      spi_sclk = 1'b1;
      spi_cs   = 1'b1;
      waitClk(HALF);
      spi_sclk = 1'b0;
      spi_sdi  = 1'b0;
      waitClk(12);
      checkOutput("cc count", wr_addr_q.size(), 1);
      checkOutput("cc addr",  wrAddrAt(0), 32'h100);
      checkOutput("cc data",  wrDataAt(0), 32'h3C);
      checkOutput("cc err",   err_pulses, 0);

      // reset during byte 2 of a streaming write, then a normal frame
      clearLog();
      spiBegin();
      sendInstr(16'h6080);
      applyStimulus(8'h5A, 8, rx);
      applyStimulus(8'hFF, 3, rx);
      reset = 1'b1;
      waitClk(2);
      checkOutput("mr reg_addr", reg_addr, 0);
      checkOutput("mr active",   frame_active, 0);
      reset = 1'b0;
      waitClk(2);
      applyStimulus(8'hFF, 5, rx);
      applyStimulus(8'h12, 8, rx);
      checkOutput("mr ignored", frame_active, 0);
      spiEnd();
      checkOutput("mr count", wr_addr_q.size(), 1);
      checkOutput("mr addr",  wrAddrAt(0), 32'h080);
      checkOutput("mr data",  wrDataAt(0), 32'h5A);
      checkOutput("mr err",   err_pulses, 0);

      clearLog();
      spiBegin();
      sendInstr(16'h0123);
      applyStimulus(8'h77, 8, rx);
      spiEnd();
      checkOutput("pr count", wr_addr_q.size(), 1);
      checkOutput("pr addr",  wrAddrAt(0), 32'h123);
      checkOutput("pr data",  wrDataAt(0), 32'h77);
      checkOutput("pr err",   err_pulses, 0);

      checkOutput("wr/rd overlap", overlap, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
